draw_trace_multi: RTL and testbench

//  Parametrised, multi-channel successor of the oscilloscope display stage.
//  - Captures decimated samples from CHANNELS ADC streams into a double-buffered store, gated by a trigger FSM.
//  - Overlays the held traces onto the VGA pixel stream passing from vga_if in to vga_if out.
//  - Sits between the background/grid drawer and the final VGA output.

---
 rtl/draw_trace_multi_if.sv | 23 ++
 rtl/draw_trace_multi.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_draw_trace_multi.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_trace_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA pixel-stream bundle: counters, syncs, blanking and
//                12-bit colour. The master modport drives the stream, the
//                slave modport receives it.
//  Fields      : vcount[10:0], hcount[10:0], vsync, hsync, vblnk, hblnk,
//                rgb[11:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport slave  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_trace_multi.sv
`default_nettype none
// ============================================================================
//  Module      : draw_trace_multi
//  Description : Multi-channel oscilloscope trace overlay. Decimated ADC
//                samples are captured into a double-buffered store under a
//                trigger FSM; the displayed bank is drawn as joined vertical
//                segments over the VGA stream passing from `in` to `out`.
//  Ports       : clk           - pixel/system clock (rising edge)
//                reset         - asynchronous, active-low reset
//                sample_valid  - sample_data valid this cycle
//                sample_data   - CHANNELS x SAMPLE_W samples, ch c at
//                                [c*SAMPLE_W +: SAMPLE_W]
//                graph_scale   - vertical right shift (clamped to SAMPLE_W)
//                time_div      - keep one of every time_div+1 valid samples
//                trig_level    - rising-edge trigger threshold on TRIG_CH
//                mode          - 00 auto, 01 normal, 10 single, 11 stop
//                arm           - re-arm pulse for single mode
//                in / out      - VGA stream, out delayed by 2 cycles
//                armed         - FSM waiting for trigger
//                capture_done  - 1-cycle pulse on buffer swap
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_trace_multi #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 1024,
    parameter int X0       = 0,
    parameter int Y0       = 128,
    parameter int GRAPH_H  = 512,
    parameter int TRIG_CH  = 0,
    parameter logic [CHANNELS-1:0][11:0] COLORS = {12'h0FF, 12'hFF0}
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         sample_valid,
    input  wire logic [CHANNELS*SAMPLE_W-1:0] sample_data,
    input  wire logic [7:0]                   graph_scale,
    input  wire logic [7:0]                   time_div,
    input  wire logic [SAMPLE_W-1:0]          trig_level,
    input  wire logic [1:0]                   mode,
    input  wire logic                         arm,
    vga_if.slave                              in,
    vga_if.master                             out,
    output logic                              armed,
    output logic                              capture_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = AW + 1;

    localparam logic [1:0] M_AUTO   = 2'b00;
    localparam logic [1:0] M_SINGLE = 2'b10;
    localparam logic [1:0] M_STOP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Capture control
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic [7:0]          dec_cnt_q, dec_cnt_d;
    logic [SAMPLE_W-1:0] trig_prev_q;
    logic                vblnk_prev_q;
    logic                disp_bank_q;
    logic                capture_done_q;

    logic                keep;
    logic                trig_hit;
    logic                timeout;
    logic                vblnk_rise;
    logic                we;
    logic                swap;
    logic [SAMPLE_W-1:0] trig_cur;

    assign trig_cur   = sample_data[TRIG_CH*SAMPLE_W +: SAMPLE_W];
    assign keep       = sample_valid && (dec_cnt_q == time_div);
    assign trig_hit   = (trig_prev_q < trig_level) && (trig_cur >= trig_level);
    assign timeout    = (mode == M_AUTO) && (to_cnt_q == TW'(DEPTH));
    assign vblnk_rise = in.vblnk && !vblnk_prev_q;

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (sample_valid) begin
            dec_cnt_d = keep ? 8'd0 : dec_cnt_q + 8'd1;
        end
    end

    // waddr_q is always 0 while ARMED (it wraps after the last write and is
    // cleared on abandon), so the triggering sample lands at address 0.
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        to_cnt_d = '0;
        we       = 1'b0;
        swap     = 1'b0;
        if (mode == M_STOP) begin
            state_d = S_IDLE;
            waddr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode != M_SINGLE || arm) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    to_cnt_d = to_cnt_q;
                    if (keep) begin
                        if (trig_hit || timeout) begin
                            we       = 1'b1;
                            waddr_d  = waddr_q + AW'(1);
                            to_cnt_d = '0;
                            state_d  = S_CAPTURE;
                        end else if (to_cnt_q != TW'(DEPTH)) begin
                            to_cnt_d = to_cnt_q + TW'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    if (keep) begin
                        we      = 1'b1;
                        waddr_d = waddr_q + AW'(1);
                        if (waddr_q == AW'(DEPTH - 1)) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (vblnk_rise) begin
                        swap    = 1'b1;
                        state_d = (mode == M_SINGLE) ? S_IDLE : S_ARMED;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            waddr_q        <= '0;
            to_cnt_q       <= '0;
            dec_cnt_q      <= '0;
            trig_prev_q    <= '0;
            vblnk_prev_q   <= 1'b0;
            disp_bank_q    <= 1'b0;
            capture_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            waddr_q        <= waddr_d;
            to_cnt_q       <= to_cnt_d;
            dec_cnt_q      <= dec_cnt_d;
            vblnk_prev_q   <= in.vblnk;
            disp_bank_q    <= disp_bank_q ^ swap;
            capture_done_q <= swap;
            if (keep) begin
                trig_prev_q <= trig_cur;
            end
        end
    end

    assign armed        = (state_q == S_ARMED);
    assign capture_done = capture_done_q;

    // ------------------------------------------------------------------
    // Display stage 1: column decode and stream delay
    // ------------------------------------------------------------------
    // 12-bit subtraction: columns left of X0 wrap to large values and fail
    // the range test together with columns right of the graph.
    logic [11:0]   col_ext;
    logic          col_ok;
    logic [AW-1:0] rd_cur;
    logic [AW-1:0] rd_prev;

    assign col_ext = {1'b0, in.hcount} - 12'(X0);
    assign col_ok  = (col_ext < 12'(DEPTH));
    assign rd_cur  = col_ext[AW-1:0];
    assign rd_prev = (rd_cur == '0) ? rd_cur : rd_cur - AW'(1);

    logic [10:0] s1_vcount_q, s1_hcount_q;
    logic        s1_vsync_q, s1_hsync_q, s1_vblnk_q, s1_hblnk_q;
    logic [11:0] s1_rgb_q;
    logic        s1_col_ok_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vcount_q <= '0;
            s1_hcount_q <= '0;
            s1_vsync_q  <= 1'b0;
            s1_hsync_q  <= 1'b0;
            s1_vblnk_q  <= 1'b0;
            s1_hblnk_q  <= 1'b0;
            s1_rgb_q    <= '0;
            s1_col_ok_q <= 1'b0;
        end else begin
            s1_vcount_q <= in.vcount;
            s1_hcount_q <= in.hcount;
            s1_vsync_q  <= in.vsync;
            s1_hsync_q  <= in.hsync;
            s1_vblnk_q  <= in.vblnk;
            s1_hblnk_q  <= in.hblnk;
            s1_rgb_q    <= in.rgb;
            s1_col_ok_q <= col_ok;
        end
    end

    // ------------------------------------------------------------------
    // Display stage 2: per-channel segment hit test
    // ------------------------------------------------------------------
    function automatic logic [11:0] to_y(input logic [SAMPLE_W-1:0] v);
        int s;
        s = int'(v);
        if (s > GRAPH_H - 1) begin
            s = GRAPH_H - 1;
        end
        return 12'(Y0 + GRAPH_H - 1 - s);
    endfunction

    logic [7:0]          shift_amt;
    logic [CHANNELS-1:0] hit;
    logic [11:0]         vc_ext;

    assign shift_amt = (graph_scale > 8'(SAMPLE_W)) ? 8'(SAMPLE_W) : graph_scale;
    assign vc_ext    = {1'b0, s1_vcount_q};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SAMPLE_W-1:0] mem [2*DEPTH];
        logic [SAMPLE_W-1:0] cur_q;
        logic [SAMPLE_W-1:0] prev_q;
        logic [11:0]         y_cur, y_prev, y_lo, y_hi;

        // Writes always target the hidden bank; reads the displayed one.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[{~disp_bank_q, waddr_q}] <= sample_data[c*SAMPLE_W +: SAMPLE_W];
            end
            cur_q  <= mem[{disp_bank_q, rd_cur}];
            prev_q <= mem[{disp_bank_q, rd_prev}];
        end

        assign y_cur  = to_y(cur_q >> shift_amt);
        assign y_prev = to_y(prev_q >> shift_amt);
        assign y_lo   = (y_cur < y_prev) ? y_cur : y_prev;
        assign y_hi   = (y_cur < y_prev) ? y_prev : y_cur;
        assign hit[c] = s1_col_ok_q && (vc_ext >= y_lo) && (vc_ext <= y_hi);
    end

    // Lowest channel index wins: scan from the top and let lower ones override.
    logic        trace_hit;
    logic [11:0] trace_rgb;

    always_comb begin
        trace_hit = 1'b0;
        trace_rgb = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (hit[c]) begin
                trace_hit = 1'b1;
                trace_rgb = COLORS[c];
            end
        end
    end

    logic [10:0] out_vcount_q, out_hcount_q;
    logic        out_vsync_q, out_hsync_q, out_vblnk_q, out_hblnk_q;
    logic [11:0] out_rgb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vcount_q <= '0;
            out_hcount_q <= '0;
            out_vsync_q  <= 1'b0;
            out_hsync_q  <= 1'b0;
            out_vblnk_q  <= 1'b0;
            out_hblnk_q  <= 1'b0;
            out_rgb_q    <= '0;
        end else begin
            out_vcount_q <= s1_vcount_q;
            out_hcount_q <= s1_hcount_q;
            out_vsync_q  <= s1_vsync_q;
            out_hsync_q  <= s1_hsync_q;
            out_vblnk_q  <= s1_vblnk_q;
            out_hblnk_q  <= s1_hblnk_q;
            if (trace_hit) begin
                out_rgb_q <= trace_rgb;
            end else if (s1_vblnk_q || s1_hblnk_q) begin
                out_rgb_q <= '0;
            end else begin
                out_rgb_q <= s1_rgb_q;
            end
        end
    end

    assign out.vcount = out_vcount_q;
    assign out.hcount = out_hcount_q;
    assign out.vsync  = out_vsync_q;
    assign out.hsync  = out_hsync_q;
    assign out.vblnk  = out_vblnk_q;
    assign out.hblnk  = out_hblnk_q;
    assign out.rgb    = out_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_trace_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_trace_multi
//  Description : Randomised bench for draw_trace_multi with a queue-based
//                capture/display reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_trace_multi;

    localparam int CH    = 2;
    localparam int SW    = 12;
    localparam int DEPTH = 1024;
    localparam int X0    = 0;
    localparam int Y0    = 128;
    localparam int GH    = 512;
    localparam int TRIG  = 0;
    localparam int FRAME = 600;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_CAP   = 2;
    localparam int P_HOLD  = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_valid;
    logic [CH*SW-1:0]    sample_data;
    logic [7:0]          graph_scale;
    logic [7:0]          time_div;
    logic [SW-1:0]       trig_level;
    logic [1:0]          mode;
    logic                arm;
    logic                armed;
    logic                capture_done;

    vga_if vin();
    vga_if vout();

    always #5 clk = ~clk;

    draw_trace_multi #(
        .CHANNELS (CH),
        .SAMPLE_W (SW),
        .DEPTH    (DEPTH),
        .X0       (X0),
        .Y0       (Y0),
        .GRAPH_H  (GH),
        .TRIG_CH  (TRIG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .graph_scale  (graph_scale),
        .time_div     (time_div),
        .trig_level   (trig_level),
        .mode         (mode),
        .arm          (arm),
        .in           (vin),
        .out          (vout),
        .armed        (armed),
        .capture_done (capture_done)
    );

    // ---------------- reference model state ----------------
    int               n_vec;
    int               n_err;
    int               phase;
    int               dcnt;
    int               wait_cnt;
    int               trig_prev;
    bit               vbl_prev;
    logic [CH*SW-1:0] pend[$];
    int               shown [CH][DEPTH];
    bit               shown_ok;
    logic [37:0]      pred_prev;
    bit               pred_prev_mask;
    logic [11:0]      colors [CH] = '{12'hFF0, 12'h0FF};

    int               cyc;
    int               ramp;
    int               valid_pct;
    int               data_kind;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int y_of(input int v);
        int sh;
        int s;
        sh = (int'(graph_scale) > SW) ? SW : int'(graph_scale);
        s  = v >> sh;
        if (s > GH - 1) s = GH - 1;
        return Y0 + GH - 1 - s;
    endfunction

    task automatic model_reset();
        phase          = P_IDLE;
        dcnt           = 0;
        wait_cnt       = 0;
        trig_prev      = 0;
        vbl_prev       = 1'b0;
        pend.delete();
        shown_ok       = 1'b0;
        pred_prev      = '0;
        pred_prev_mask = 1'b0;
    endtask

    // The next check compares against a prediction made with the old scale;
    // hide its colour since the DUT applies the new scale one cycle later.
    task automatic set_scale(input int v);
        graph_scale    = 8'(v);
        pred_prev_mask = 1'b1;
    endtask

    task automatic step();
        logic [37:0] pd;
        logic [37:0] got;
        logic [37:0] exp;
        logic [11:0] rgb_e;
        bit          pm;
        bit          vrise;
        bit          kept;
        bit          done_e;
        int          cur0;
        int          col;
        int          yc, yp, lo, hi;

        // stimulus
        cyc++;
        vin.hcount   = 11'($urandom_range(1200));
        vin.vcount   = 11'($urandom_range(700, 100));
        vin.vsync    = 1'($urandom);
        vin.hsync    = 1'($urandom);
        vin.hblnk    = ($urandom_range(9) == 0);
        vin.vblnk    = ((cyc % FRAME) >= FRAME - 40);
        vin.rgb      = 12'($urandom);
        sample_valid = ($urandom_range(99) < valid_pct);
        case (data_kind)
            0: begin
                sample_data = {12'($urandom), 12'(ramp)};
                if (sample_valid) ramp++;
            end
            1:       sample_data = {12'd50, 12'd50};
            default: sample_data = {12'($urandom), 12'($urandom)};
        endcase

        // display prediction uses the trace shown before this edge
        col   = int'(vin.hcount) - X0;
        pm    = 1'b0;
        rgb_e = (vin.vblnk || vin.hblnk) ? 12'h000 : vin.rgb;
        if (col >= 0 && col < DEPTH) begin
            if (!shown_ok) begin
                pm = 1'b1;
            end else begin
                for (int c = CH - 1; c >= 0; c--) begin
                    yc = y_of(shown[c][col]);
                    yp = y_of(shown[c][(col == 0) ? 0 : col - 1]);
                    lo = (yc < yp) ? yc : yp;
                    hi = (yc < yp) ? yp : yc;
                    if (int'(vin.vcount) >= lo && int'(vin.vcount) <= hi) rgb_e = colors[c];
                end
            end
        end
        pd = {vin.vcount, vin.hcount, vin.vsync, vin.hsync, vin.vblnk, vin.hblnk, rgb_e};

        // capture behaviour
        vrise    = vin.vblnk && !vbl_prev;
        vbl_prev = vin.vblnk;
        cur0     = int'(sample_data[TRIG*SW +: SW]);
        kept     = 1'b0;
        if (sample_valid) begin
            if (dcnt == int'(time_div)) begin
                kept = 1'b1;
                dcnt = 0;
            end else begin
                dcnt = (dcnt + 1) % 256;
            end
        end
        done_e = 1'b0;
        if (mode == 2'b11) begin
            phase = P_IDLE;
            pend.delete();
        end else begin
            case (phase)
                P_IDLE: begin
                    if (mode != 2'b10 || arm) begin
                        phase    = P_ARMED;
                        wait_cnt = 0;
                    end
                end
                P_ARMED: begin
                    if (kept) begin
                        if ((trig_prev < int'(trig_level) && cur0 >= int'(trig_level)) ||
                            (mode == 2'b00 && wait_cnt >= DEPTH)) begin
                            pend.delete();
                            pend.push_back(sample_data);
                            phase = P_CAP;
                        end else begin
                            wait_cnt++;
                        end
                    end
                end
                P_CAP: begin
                    if (kept) begin
                        pend.push_back(sample_data);
                        if (pend.size() == DEPTH) phase = P_HOLD;
                    end
                end
                default: begin
                    if (vrise) begin
                        for (int i = 0; i < DEPTH; i++)
                            for (int c = 0; c < CH; c++)
                                shown[c][i] = int'(pend[i][c*SW +: SW]);
                        shown_ok = 1'b1;
                        done_e   = 1'b1;
                        phase    = (mode == 2'b10) ? P_IDLE : P_ARMED;
                        wait_cnt = 0;
                    end
                end
            endcase
        end
        if (kept) trig_prev = cur0;

        @(posedge clk);
        #1;
        chk("armed", 64'(armed), 64'(phase == P_ARMED));
        chk("capture_done", 64'(capture_done), 64'(done_e));
        got = {vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk, vout.rgb};
        exp = pred_prev;
        if (pred_prev_mask) begin
            got[11:0] = '0;
            exp[11:0] = '0;
        end
        chk("vga_out", 64'(got), 64'(exp));
        pred_prev      = pd;
        pred_prev_mask = pm;
    endtask

    // Called aligned just after a rising edge; asserts reset between edges.
    task automatic apply_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_done", 64'(capture_done), 64'd0);
        chk("rst_out", 64'({vout.vcount, vout.hcount, vout.vsync, vout.hsync,
                             vout.vblnk, vout.hblnk, vout.rgb}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    task automatic run_until_capture(input int n_after);
        for (int i = 0; i < 6000 && phase != P_CAP; i++) step();
        repeat (n_after) step();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        cyc          = 0;
        ramp         = 0;
        valid_pct    = 100;
        data_kind    = 0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        graph_scale  = 8'd3;
        time_div     = 8'd0;
        trig_level   = 12'd100;
        mode         = 2'b00;
        arm          = 1'b0;
        vin.hcount   = '0;
        vin.vcount   = '0;
        vin.vsync    = 1'b0;
        vin.hsync    = 1'b0;
        vin.vblnk    = 1'b0;
        vin.hblnk    = 1'b0;
        vin.rgb      = '0;
        model_reset();

        // reset, then auto mode arms on the first edge
        apply_reset();
        repeat (10) step();

        // normal mode, ramp through the trigger level, scale 3
        mode = 2'b01;
        repeat (3000) step();

        // auto mode, constant input below trigger, time_div=1 -> forced captures
        mode       = 2'b00;
        time_div   = 8'd1;
        data_kind  = 1;
        repeat (5000) step();

        // single mode: one capture then idle, arm pulse gives a second one
        mode       = 2'b10;
        time_div   = 8'd0;
        data_kind  = 2;
        valid_pct  = 70;
        trig_level = 12'd2048;
        set_scale($urandom_range(14));
        repeat (3000) step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (3000) step();

        // normal mode with a stop mid-capture: old trace stays displayed
        mode = 2'b01;
        set_scale(0);
        run_until_capture(100);
        mode = 2'b11;
        repeat (4) step();
        mode = 2'b01;
        repeat (2500) step();

        // reset in the middle of a capture, release in auto mode
        mode = 2'b00;
        run_until_capture(50);
        apply_reset();
        repeat (5) step();

        // auto mode, random decimation and data
        time_div  = 8'($urandom_range(2));
        valid_pct = 80;
        set_scale(2);
        repeat (4000) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
